// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with 2-flop synchroniser, framing-error and busy reporting.
// Define UART_RX_PARITY_EN for 8E1 frames with a parErrOUT strobe.
module uart_rx_core #(
  parameter int clkFreq = 48_000_000,
  parameter int baudRate = 9600
) (
  input  logic       clkIN,
  input  logic       nResetIN,
  input  logic       rxIN,
  output logic [7:0] dataOUT,
  output logic       validOUT,
  output logic       frameErrOUT,
`ifdef UART_RX_PARITY_EN
  output logic       parErrOUT,
`endif
  output logic       nBusyOUT
);
  localparam int BIT_CNT = clkFreq / baudRate;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW = $clog2(BIT_CNT);
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);

  if (BIT_CNT < 8) begin : gBitCntCheck
    $error("uart_rx_core: clkFreq/baudRate must be at least 8");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t state;
  logic rxMeta, rxS, armed;
  logic [1:0] syncAge;
  logic [CW-1:0] cnt;
  logic [2:0] bitIdx;
  logic [7:0] shiftReg;
`ifdef UART_RX_PARITY_EN
  logic parBit;
`endif

  // syncAge marks when rxS carries real line data rather than its reset value
  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      rxMeta <= 1'b1;
      rxS <= 1'b1;
      syncAge <= 2'b00;
    end else begin
      rxMeta <= rxIN;
      rxS <= rxMeta;
      syncAge <= {syncAge[0], 1'b1};
    end
  end

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state <= IDLE;
      cnt <= '0;
      bitIdx <= '0;
      shiftReg <= '0;
      dataOUT <= '0;
      validOUT <= 1'b0;
      frameErrOUT <= 1'b0;
      nBusyOUT <= 1'b1;
      armed <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parErrOUT <= 1'b0;
      parBit <= 1'b0;
`endif
    end else begin
      validOUT <= 1'b0;
      frameErrOUT <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parErrOUT <= 1'b0;
`endif
      armed <= armed | (syncAge[1] & rxS);
      case (state)
        IDLE: begin
          if (armed && !rxS) begin
            state <= START;
            cnt <= '0;
            nBusyOUT <= 1'b0;
          end else begin
            nBusyOUT <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            bitIdx <= '0;
            state <= rxS ? IDLE : DATA;
            nBusyOUT <= rxS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            shiftReg[bitIdx] <= rxS;
            bitIdx <= bitIdx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bitIdx == 3'd7) state <= PARITY;
`else
            if (bitIdx == 3'd7) state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            parBit <= rxS;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            state <= rxS ? IDLE : WAIT_HIGH;
            nBusyOUT <= rxS;
            frameErrOUT <= !rxS;
`ifdef UART_RX_PARITY_EN
            if (rxS && (parBit != ^shiftReg)) begin
              parErrOUT <= 1'b1;
            end else if (rxS) begin
              dataOUT <= shiftReg;
              validOUT <= 1'b1;
            end
`else
            if (rxS) begin
              dataOUT <= shiftReg;
              validOUT <= 1'b1;
            end
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxS) begin
            state <= IDLE;
            cnt <= '0;
            nBusyOUT <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized frame stimulus with a scoreboard of expected strobes.
module tb_uart_rx_core;
  localparam int BIT = 16;
  localparam int HALF = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic clk = 1'b0;
  logic nResetIN = 1'b1;
  logic rxIN = 1'b1;
  logic [7:0] dataOUT;
  logic validOUT, frameErrOUT, nBusyOUT, parErrS;

  always #5 clk = ~clk;

  uart_rx_core #(.clkFreq(160), .baudRate(10)) dut (
    .clkIN(clk),
    .nResetIN(nResetIN),
    .rxIN(rxIN),
    .dataOUT(dataOUT),
    .validOUT(validOUT),
    .frameErrOUT(frameErrOUT),
`ifdef UART_RX_PARITY_EN
    .parErrOUT(parErrS),
`endif
    .nBusyOUT(nBusyOUT)
  );
`ifndef UART_RX_PARITY_EN
  assign parErrS = 1'b0;
`endif

  int checks = 0;
  int fails = 0;
  int expKind[$];
  logic [7:0] expData[$];
  logic [7:0] modelData = 8'h00;
  int busyRun = 0;
  int lastBusyRun = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // kind 1 = valid byte, 2 = framing error, 3 = parity error
  task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic parFlip);
    logic [10:0] bits;
    int n;
`ifdef UART_RX_PARITY_EN
    bits = {stopBit, (^d) ^ parFlip, d, 1'b0};
    n = 11;
    expKind.push_back(!stopBit ? 2 : (parFlip ? 3 : 1));
`else
    bits = {parFlip, stopBit, d, 1'b0};
    n = 10;
    expKind.push_back(stopBit ? 1 : 2);
`endif
    expData.push_back(d);
    for (int i = 0; i < n; i++) begin
      rxIN = bits[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rxIN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    int k, ek;
    logic [7:0] ed;
    if (!nResetIN) begin
      modelData = 8'h00;
      busyRun = 0;
    end else begin
      if (!nBusyOUT) busyRun++;
      else if (busyRun != 0) begin
        lastBusyRun = busyRun;
        busyRun = 0;
      end
      if (validOUT || frameErrOUT || parErrS) begin
        k = validOUT ? 1 : (frameErrOUT ? 2 : 3);
        check("strobe exclusive", int'(validOUT) + int'(frameErrOUT) + int'(parErrS), 1);
        if (expKind.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected strobe: got kind %0d, expected none", k);
        end else begin
          ek = expKind.pop_front();
          ed = expData.pop_front();
          check("strobe kind", k, ek);
          if (ek == 1) modelData = ed;
          check("dataOUT at strobe", dataOUT, modelData);
        end
      end
    end
  end

  initial begin
    logic [10:0] bits;
    logic [7:0] d;
    logic stopBit;
    #1 nResetIN = 1'b0;
    repeat (3) @(negedge clk);
    check("reset dataOUT", dataOUT, 0);
    check("reset validOUT", validOUT, 0);
    check("reset frameErrOUT", frameErrOUT, 0);
    check("reset nBusyOUT", nBusyOUT, 1);
    nResetIN = 1'b1;
    idle(4);

    lastBusyRun = 0;
    sendFrame(8'h41, 1'b1, 1'b0);
    idle(4);
    check("busy length 0x41", int'(lastBusyRun >= HALF + NB * BIT - 3 && lastBusyRun <= HALF + NB * BIT + 3), 1);
    check("idle after 0x41", nBusyOUT, 1);

    lastBusyRun = 0;
    rxIN = 1'b0;
    repeat (3) @(negedge clk);
    idle(3 * BIT);
    check("glitch busy length", int'(lastBusyRun >= HALF - 2 && lastBusyRun <= HALF + 2), 1);
    check("idle after glitch", nBusyOUT, 1);

    sendFrame(8'h7E, 1'b0, 1'b0);
    repeat (20 * BIT) @(negedge clk);
    check("busy during break", nBusyOUT, 0);
    check("dataOUT kept after break", dataOUT, 8'h41);
    idle(5);
    check("idle after break", nBusyOUT, 1);
    idle(BIT);

    sendFrame(8'h55, 1'b1, 1'b0);
    sendFrame(8'hAA, 1'b1, 1'b0);
    idle(2 * BIT);

    // reset lands in data bit 4 and is released in data bit 6 (line low)
    bits = {2'b10, 8'h33, 1'b0};
    for (int i = 0; i < NB + 1; i++) begin
      rxIN = bits[i];
      if (i == 5) begin
        repeat (HALF) @(negedge clk);
        nResetIN = 1'b0;
        #1;
        check("midframe reset dataOUT", dataOUT, 0);
        check("midframe reset validOUT", validOUT, 0);
        check("midframe reset frameErrOUT", frameErrOUT, 0);
        check("midframe reset nBusyOUT", nBusyOUT, 1);
        repeat (BIT - HALF) @(negedge clk);
      end else if (i == 7) begin
        repeat (HALF) @(negedge clk);
        nResetIN = 1'b1;
        repeat (BIT - HALF) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
    idle(2 * BIT);
    sendFrame(8'h33, 1'b1, 1'b0);
    idle(2 * BIT);

`ifdef UART_RX_PARITY_EN
    sendFrame(8'h03, 1'b1, 1'b0);
    idle(BIT);
    sendFrame(8'h03, 1'b1, 1'b1);
    idle(BIT);
`endif

    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      stopBit = ($urandom_range(0, 3) != 0);
      sendFrame(d, stopBit, 1'($urandom_range(0, 1)));
      if (!stopBit) idle(BIT);
      idle($urandom_range(0, 4));
    end

    idle(3 * BIT);
    check("scoreboard drained", expKind.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
